// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the writeback sources and the arbiter, plus the
// registered write port that the arbiter drives into the register file.
// master: writeback source side, slave: arbiter side.
interface regfile_wb_arbiter_if #(
    parameter int NREQ   = 3,
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5
);
    localparam int GID_W = $clog2(NREQ);

    logic                     wb_stall;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ*ADDR_W-1:0]   req_rd;
    logic [NREQ*XLEN-1:0]     req_data;
    logic                     w_en;
    logic [ADDR_W-1:0]        rd;
    logic [XLEN-1:0]          w_data;
    logic [GID_W-1:0]         grant_id;

    modport master (
        output wb_stall, req_valid, req_rd, req_data,
        input  req_ready, w_en, rd, w_data, grant_id
    );

    modport slave (
        input  wb_stall, req_valid, req_rd, req_data,
        output req_ready, w_en, rd, w_data, grant_id
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among
// NREQ writeback sources. Grant is combinational; the winning write is
// registered and presented to the register file for one cycle.
// Optional feature: define WB_ARB_STATS_EN to add per-source saturating
// grant counters (stat_clr / stat_grant ports).
module regfile_wb_arbiter #(
    parameter int NREQ   = 3,
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_wb_arbiter_if.slave   bus
`ifdef WB_ARB_STATS_EN
    ,
    input  logic                  stat_clr,
    output logic [NREQ*16-1:0]    stat_grant
`endif
);
    localparam int GID_W = $clog2(NREQ);

    logic [GID_W-1:0]  ptr_q, ptr_d;
    logic [GID_W-1:0]  gnt_idx;
    logic              hs;
    logic [NREQ-1:0]   ready;
    logic [ADDR_W-1:0] sel_rd;
    logic [XLEN-1:0]   sel_data;

    logic              w_en_q, w_en_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0]   w_data_q, w_data_d;
    logic [GID_W-1:0]  gid_q, gid_d;

    // Round-robin search from ptr upward; stall or reset suppress any grant
    always_comb begin
        int idx;
        idx     = 0;
        hs      = 1'b0;
        gnt_idx = '0;
        ready   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!hs && bus.req_valid[idx]) begin
                hs      = 1'b1;
                gnt_idx = GID_W'(idx);
            end
        end
        if (rst || bus.wb_stall) begin
            hs = 1'b0;
        end
        if (hs) begin
            ready[gnt_idx] = 1'b1;
        end
    end

    assign bus.req_ready = ready;
    assign sel_rd        = bus.req_rd[gnt_idx*ADDR_W +: ADDR_W];
    assign sel_data      = bus.req_data[gnt_idx*XLEN +: XLEN];

    // Next-state: capture the granted write, advance the pointer past the winner
    always_comb begin
        ptr_d    = ptr_q;
        w_en_d   = 1'b0;
        rd_d     = rd_q;
        w_data_d = w_data_q;
        gid_d    = gid_q;
        if (hs) begin
            ptr_d    = (gnt_idx == GID_W'(NREQ - 1)) ? '0 : gnt_idx + GID_W'(1);
            // x0 writes still complete the handshake but never enable the file
            w_en_d   = (sel_rd != '0);
            rd_d     = sel_rd;
            w_data_d = sel_data;
            gid_d    = gnt_idx;
        end
    end

    // Pointer and write-port registers; reset clears any beat registered this cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q    <= '0;
            w_en_q   <= 1'b0;
            rd_q     <= '0;
            w_data_q <= '0;
            gid_q    <= '0;
        end else begin
            ptr_q    <= ptr_d;
            w_en_q   <= w_en_d;
            rd_q     <= rd_d;
            w_data_q <= w_data_d;
            gid_q    <= gid_d;
        end
    end

    assign bus.w_en     = w_en_q;
    assign bus.rd       = rd_q;
    assign bus.w_data   = w_data_q;
    assign bus.grant_id = gid_q;

`ifdef WB_ARB_STATS_EN
    logic [15:0] cnt_q [NREQ];
    logic [15:0] cnt_d [NREQ];

    // Saturating per-source grant counters; clear beats a same-cycle increment
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (stat_clr) begin
                cnt_d[i] = '0;
            end else if (hs && gnt_idx == GID_W'(i) && cnt_q[i] != 16'hFFFF) begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (rst) begin
                cnt_q[i] <= '0;
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_stat
        assign stat_grant[g*16 +: 16] = cnt_q[g];
    end
`endif
endmodule
